// File: rtl/float_to_int.sv
// IEEE-754 single-precision to signed integer converter: round toward zero,
// saturating, with NaN/overflow/inexact flags. Two-stage valid/ready pipeline.
module float_to_int #(
    parameter int unsigned INT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_nan,
    output logic             out_inexact
);

    typedef enum logic [1:0] {
        KindNorm,
        KindSmall,
        KindInf,
        KindNan
    } kind_e;

    localparam logic [6:0]       MaxE   = 7'(INT_W - 1);
    localparam logic [INT_W-1:0] SatPos = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SatNeg = {1'b1, {(INT_W-1){1'b0}}};

    // Handshake
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: classify
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_man;
    logic [7:0]  in_unbiased;
    kind_e       in_kind;

    assign in_sign     = in_data[31];
    assign in_exp      = in_data[30:23];
    assign in_man      = in_data[22:0];
    assign in_unbiased = in_exp - 8'd127;

    always_comb begin
        in_kind = KindNorm;
        if (in_exp == 8'hFF) begin
            in_kind = (in_man != 23'd0) ? KindNan : KindInf;
        end else if (in_exp < 8'd127) begin
            in_kind = KindSmall;
        end
    end

    kind_e       s1_kind;
    logic        s1_sign;
    logic [6:0]  s1_exp;
    logic [23:0] s1_man;
    logic        s1_small_nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_kind     <= in_kind;
            s1_sign     <= in_sign;
            s1_exp      <= in_unbiased[6:0];
            s1_man      <= {1'b1, in_man};
            s1_small_nz <= (in_exp != 8'd0) || (in_man != 23'd0);
        end
    end

    // Stage 2: convert
    logic [31:0]      mant_ext;
    logic [31:0]      mag;
    logic [31:0]      lost;
    logic [6:0]       sh_left;
    logic [6:0]       sh_right;
    logic [INT_W-1:0] mag_n;
    logic [INT_W-1:0] cv_data;
    logic             cv_ovf;
    logic             cv_nan;
    logic             cv_inexact;

    assign mant_ext = {8'd0, s1_man};
    assign sh_left  = s1_exp - 7'd23;
    assign sh_right = 7'd23 - s1_exp;

    always_comb begin
        mag  = 32'd0;
        lost = 32'd0;
        if (s1_exp >= 7'd23) begin
            mag = mant_ext << sh_left;
        end else begin
            mag  = mant_ext >> sh_right;
            lost = mant_ext & ~(32'hFFFF_FFFF << sh_right);
        end
    end

    assign mag_n = mag[INT_W-1:0];

    always_comb begin
        cv_data    = '0;
        cv_ovf     = 1'b0;
        cv_nan     = 1'b0;
        cv_inexact = 1'b0;
        unique case (s1_kind)
            KindNan: begin
                cv_nan = 1'b1;
            end
            KindInf: begin
                cv_ovf  = 1'b1;
                cv_data = s1_sign ? SatNeg : SatPos;
            end
            KindSmall: begin
                cv_inexact = s1_small_nz;
            end
            default: begin
                if (s1_exp >= MaxE) begin
                    // The most negative integer is the only representable value at this exponent.
                    if (s1_sign && s1_exp == MaxE && s1_man[22:0] == 23'd0) begin
                        cv_data = SatNeg;
                    end else begin
                        cv_ovf  = 1'b1;
                        cv_data = s1_sign ? SatNeg : SatPos;
                    end
                end else begin
                    cv_data    = s1_sign ? -mag_n : mag_n;
                    cv_inexact = (lost != 32'd0);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ovf     <= 1'b0;
            out_nan     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= cv_data;
                out_ovf     <= cv_ovf;
                out_nan     <= cv_nan;
                out_inexact <= cv_inexact;
            end
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: drives 32-bit and 16-bit instances with the same
// stream and checks both against an arithmetic reference model.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, ovf_a, nan_a, inex_a;
    logic [31:0] out_data_a;
    logic        in_ready_b, out_valid_b, ovf_b, nan_b, inex_b;
    logic [15:0] out_data_b;

    always #5 clk = ~clk;

    float_to_int #(.INT_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ovf(ovf_a), .out_nan(nan_a), .out_inexact(inex_a)
    );

    float_to_int #(.INT_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ovf(ovf_b), .out_nan(nan_b), .out_inexact(inex_b)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        nan;
        logic        inexact;
    } res_t;

    typedef struct {
        res_t r;
        int   stamp;
    } item_t;

    item_t q32[$];
    res_t  q16[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    bit    lat_en = 1'b0;
    bit    rand_rdy = 1'b0;
    item_t it;
    res_t  rb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value-level reference: exact integer part and fraction, then range check.
    function automatic res_t model(input logic [31:0] f, input int w);
        res_t         r;
        logic [159:0] mant, ip, lim;
        logic [31:0]  lim32;
        int           e, sh;
        bit           fnz;
        r     = '0;
        e     = int'(f[30:23]);
        lim   = 160'd1 << (w - 1);
        lim32 = lim[31:0];
        if (e == 255) begin
            if (f[22:0] != 23'd0) r.nan = 1'b1;
            else begin
                r.ovf  = 1'b1;
                r.data = f[31] ? -lim32 : lim32 - 32'd1;
            end
            return r;
        end
        mant       = '0;
        mant[22:0] = f[22:0];
        if (e != 0) mant[23] = 1'b1;
        sh = (e == 0) ? -149 : e - 150;
        if (sh >= 0) begin
            ip  = mant << sh;
            fnz = 1'b0;
        end else begin
            ip  = mant >> (-sh);
            fnz = ((ip << (-sh)) != mant);
        end
        if ((!f[31] && ip >= lim) || (f[31] && (ip > lim || (ip == lim && fnz)))) begin
            r.ovf  = 1'b1;
            r.data = f[31] ? -lim32 : lim32 - 32'd1;
        end else begin
            r.data    = f[31] ? -ip[31:0] : ip[31:0];
            r.inexact = fnz;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        f = $urandom;
        case ($urandom_range(0, 7))
            0: ;
            1: begin
                f[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 1) f[22:0] = 23'd0;
            end
            2: f[30:23] = 8'($urandom_range(0, 126));
            3: begin
                f[30:23] = 8'($urandom_range(140, 160));
                if ($urandom_range(0, 1) == 1) f[15:0] = 16'd0;
            end
            4: begin
                case ($urandom_range(0, 3))
                    0: f[30:23] = 8'd142;
                    1: f[30:23] = 8'd143;
                    2: f[30:23] = 8'd157;
                    default: f[30:23] = 8'd158;
                endcase
                if ($urandom_range(0, 1) == 1) f[22:0] = 23'd0;
            end
            default: f[30:23] = 8'($urandom_range(120, 165));
        endcase
        return f;
    endfunction

    // Scoreboard monitor; sampled on the falling edge, transfers happen on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_a && out_ready) begin
                if (q32.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out32: got %h, expected no output", out_data_a);
                end else begin
                    it = q32.pop_front();
                    check("data32", out_data_a, it.r.data);
                    check("flags32", {29'd0, ovf_a, nan_a, inex_a},
                          {29'd0, it.r.ovf, it.r.nan, it.r.inexact});
                    if (lat_en) check("latency", 32'(cyc + 1 - it.stamp), 32'd2);
                end
            end
            if (out_valid_b && out_ready) begin
                if (q16.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out16: got %h, expected no output", out_data_b);
                end else begin
                    rb = q16.pop_front();
                    check("data16", {16'd0, out_data_b}, {16'd0, rb.data[15:0]});
                    check("flags16", {29'd0, ovf_b, nan_b, inex_b},
                          {29'd0, rb.ovf, rb.nan, rb.inexact});
                end
            end
            if (lat_en && in_valid) check("in_ready_stream", {31'd0, in_ready_a}, 32'd1);
            if (in_valid && in_ready_a) begin
                it.r     = model(in_data, 32);
                it.stamp = cyc + 1;
                q32.push_back(it);
            end
            if (in_valid && in_ready_b) q16.push_back(model(in_data, 16));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] v);
        int t;
        bit acc;
        t        = 0;
        in_valid = 1'b1;
        in_data  = v;
        forever begin
            @(negedge clk);
            acc = in_ready_a;
            step();
            if (acc) break;
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready=0, expected accept of %h", v);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        int t;
        t         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q32.size() != 0 || q16.size() != 0) && t < 100) begin
            step();
            t++;
        end
        idle(2);
        check("drain_empty", 32'(q32.size() + q16.size()), 32'd0);
    endtask

    logic [31:0] dir_vals[14] = '{
        32'h4F000000, 32'hCF000000, 32'hFF800000, 32'h7FC00000, 32'h80000000,
        32'h00000001, 32'h3F000000, 32'h46FFFE00, 32'h47000000, 32'hC7000000,
        32'h7F800000, 32'h4EFFFFFF, 32'hCF000001, 32'hC7000080
    };
    logic [31:0] bp_vals[4] = '{32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

    initial begin
        int  idx;
        bit  acc_now;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid32", {31'd0, out_valid_a}, 32'd0);
        check("rst_data32", out_data_a, 32'd0);
        check("rst_flags32", {29'd0, ovf_a, nan_a, inex_a}, 32'd0);
        check("rst_valid16", {31'd0, out_valid_b}, 32'd0);
        check("rst_data16", {16'd0, out_data_b}, 32'd0);
        rst_n = 1'b1;
        step();

        // Unstalled stream with fixed latency
        out_ready = 1'b1;
        lat_en    = 1'b1;
        send(32'h3F800000);
        send(32'hC0490FDB);
        send(32'h3F801000);
        idle(4);
        lat_en = 1'b0;

        foreach (dir_vals[i]) send(dir_vals[i]);
        drain();

        // Back-pressure: only two items fit while the sink stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        idx       = 0;
        in_data   = bp_vals[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc_now = in_ready_a;
            if (out_valid_a) check("stall_hold", out_data_a, 32'd7);
            step();
            if (acc_now && idx < 3) begin
                idx++;
                in_data = bp_vals[idx];
            end
        end
        check("bp_accepted", 32'(idx), 32'd2);
        @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
        step();
        out_ready = 1'b1;
        send(bp_vals[2]);
        send(bp_vals[3]);
        drain();

        // Randomized traffic with random sink stalls
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(rand_float());
        end
        rand_rdy = 1'b0;
        drain();

        // Asynchronous reset with two items in flight
        out_ready = 1'b0;
        send(32'h40400000);
        send(32'h40800000);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid32", {31'd0, out_valid_a}, 32'd0);
        check("arst_valid16", {31'd0, out_valid_b}, 32'd0);
        q32.delete();
        q16.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        lat_en    = 1'b1;
        send(32'h40A00000);
        idle(4);
        lat_en = 1'b0;
        check("post_reset_empty", 32'(q32.size() + q16.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Downstream consumer of the `float_add` result word.
- Converts an IEEE-754 single-precision value to a signed two's-complement integer, rounding toward zero, with saturation and status flags.
- Two-stage pipeline with valid/ready handshake on both sides so a stalled sink back-pressures the adder's result path.

Parameters:
- INT_W, 32, output integer width in bits; legal range 8..32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  `in_data` holds a valid float this cycle.
- in_ready  output  1  block accepts `in_data` this cycle.
- in_data  input  32  float: sign [31], exponent [30:23], mantissa [22:0].
- out_valid  output  1  `out_data` and flags are valid.
- out_ready  input  1  sink accepts output this cycle.
- out_data  output  INT_W  signed integer result.
- out_ovf  output  1  result saturated (overflow or ±inf).
- out_nan  output  1  input was NaN.
- out_inexact  output  1  nonzero fraction bits discarded.

Behaviour:
- Reset (`rst_n` low, asynchronous): both stage-valid bits = 0; `out_valid` = 0; `out_data` = 0; all flags = 0. Data registers need no reset except the output registers.
- Transfer rules:
  - Input transfer when `in_valid && in_ready`.
  - Output transfer when `out_valid && out_ready`.
  - Stage 2 advances when `!s2_valid || out_ready`.
  - Stage 1 advances when `!s1_valid || stage2 advances`.
  - `in_ready` = stage 1 advances; it is combinational from `out_ready` and the valid bits only, never from `in_valid`.
- Latency: exactly 2 cycles from input transfer to `out_valid` when unstalled. Throughput: 1 per cycle. No bubbles inserted while `out_ready` stays high.
- Stall: while `out_valid && !out_ready`, output registers hold all values stable. At most 2 items are held in flight; `in_ready` = 0 once both stages are full.
- Stage 1 (classify):
  - `exp == 255 && man != 0` → NaN.
  - `exp == 255 && man == 0` → Inf.
  - `exp < 127` → small.
  - Otherwise compute unbiased E = exp − 127 (0..127) and register sign, E, and {1, man}.
- Stage 2 (convert) results:
  - NaN → `out_data` = 0, `out_nan` = 1, `out_ovf` = 0, `out_inexact` = 0.
  - Inf → saturate, `out_ovf` = 1.
  - Small → `out_data` = 0; `out_inexact` = 1 iff exp != 0 or man != 0. Denormals and ±0 give 0; −0 gives 0.
  - E ≥ INT_W−1 → overflow, except the exact minimum: sign = 1, E = INT_W−1, man = 0 gives −2^(INT_W−1) with `out_ovf` = 0.
  - Saturation values: positive → 2^(INT_W−1)−1; negative → −2^(INT_W−1). `out_inexact` = 0 when saturated.
- Stage 2 magnitude and sign:
  - Otherwise magnitude = {1, man} << (E−23) if E ≥ 23, else {1, man} >> (23−E).
  - `out_inexact` = 1 iff any shifted-out bit is nonzero.
  - Sign applied by two's-complement negation; magnitude is always < 2^(INT_W−1) here.
- Simultaneous accept and emit in the same cycle with both stages full: legal; the pipeline shifts, with no loss or duplication.
- Reset asserted mid-stream: in-flight items are discarded. After release, the first output is the first input accepted post-reset.

Test Plan:
- Stream 0x3F800000 (1.0), 0xC0490FDB (−3.14159), 0x3F801000, `out_ready` = 1 → outputs 1 (inexact 0), −3 (inexact 1), 1 (inexact 1), on cycles 2, 3, 4 after the first accept; `in_ready` stays 1 throughout.
- 0x4F000000 (2^31) → 0x7FFFFFFF, ovf = 1. 0xCF000000 (−2^31) → 0x80000000, ovf = 0, inexact = 0. 0xFF800000 (−inf) → 0x80000000, ovf = 1.
- 0x7FC00000 (NaN) → 0, nan = 1. 0x80000000 (−0) → 0, all flags 0. 0x00000001 (denormal) → 0, inexact = 1. 0x3F000000 (0.5) → 0, inexact = 1.
- Back-pressure: `out_ready` = 0, `in_valid` = 1 with 4 distinct values → exactly 2 accepted, then `in_ready` = 0 and `out_data` holds the first value stable. Raise `out_ready` → all 4 results emerge in order, none dropped or duplicated.
- Parameter INT_W = 16: 0x46FFFE00 (32767.0) → 0x7FFF, ovf = 0; 0x47000000 (32768.0) → 0x7FFF, ovf = 1; 0xC7000000 → 0x8000, ovf = 0.
- Pull `rst_n` low asynchronously (off clock edge) with 2 items in flight → `out_valid` = 0 immediately. After release, feed 0x40A00000 → 5 appears 2 cycles after accept, with no stale outputs.
